// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two adjacent pipeline stages around one pipe_stage_reg.
// The slave modport is the stage itself; the master modport is whatever drives and observes it.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 96
) ();
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_i;
    logic              valid_o;
    logic              ready_i;
    logic [DATA_W-1:0] data_o;
    logic [1:0]        level_o;

    modport slave (
        input  flush_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, level_o
    );

    modport master (
        output flush_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, level_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, flush and optional two-entry skid.
// With SKID=1 ready_o is decoded from occupancy only, cutting the combinational ready chain.
module pipe_stage_reg #(
    parameter int                 DATA_W     = 96,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
    parameter int                 SKID       = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    pipe_stage_reg_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] main_p0;
    logic [DATA_W-1:0] skid_p0;
    logic              vld_p0;
    logic              ready;
    logic              acc;
    logic              emit;
    logic              load_main;
    logic              load_skid;
    logic              main_from_skid;

    function automatic logic [DATA_W-1:0] mask_bubble(input logic vld, input logic [DATA_W-1:0] val);
        return vld ? val : BUBBLE_VAL;
    endfunction

    assign vld_p0 = (state != EMPTY);

    always_comb begin
        ready = 1'b0;
        if (rst_i) begin
            if (SKID != 0) ready = (state != TWO);
            else           ready = (state == EMPTY) || bus.ready_i;
        end
    end

    assign acc  = bus.valid_i && ready;
    assign emit = vld_p0 && bus.ready_i;

    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (bus.flush_i) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_next = ONE;
                        load_main  = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && emit) begin
                        load_main = 1'b1;
                    end else if (acc) begin
                        // Only reachable with a skid entry; single-entry mode cannot accept while stalled.
                        if (SKID != 0) begin
                            state_next = TWO;
                            load_skid  = 1'b1;
                        end
                    end else if (emit) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (emit) begin
                        state_next     = ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // stage p0: occupancy control (reset) and payload registers (no reset)
    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= EMPTY;
        else        state <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (load_main)           main_p0 <= bus.data_i;
        else if (main_from_skid) main_p0 <= skid_p0;
    end

    generate
        if (SKID != 0) begin : g_skid
            always_ff @(posedge clk_i) begin
                if (load_skid) skid_p0 <= bus.data_i;
            end
        end else begin : g_noskid
            assign skid_p0 = '0;
        end
    endgenerate

    assign bus.ready_o = ready;
    assign bus.valid_o = vld_p0;
    assign bus.data_o  = mask_bubble(vld_p0, main_p0);
    assign bus.level_o = state;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one single-entry and one skid instance share stimulus; each has
// its own queue of accepted beats that a monitor checks against every cycle.
module tb_pipe_stage_reg;
    localparam int             DW  = 16;
    localparam logic [DW-1:0]  BUB = 16'hBEEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : lane
            localparam int SK = g;

            pipe_stage_reg_if #(.DATA_W(DW)) bus ();
            assign bus.flush_i = flush;
            assign bus.valid_i = valid;
            assign bus.data_i  = data;
            assign bus.ready_i = ready;

            pipe_stage_reg #(
                .DATA_W    (DW),
                .BUBBLE_VAL(BUB),
                .SKID      (SK)
            ) dut (
                .clk_i(clk),
                .rst_i(rst),
                .bus  (bus.slave)
            );

            logic [DW-1:0] sb[$];
            logic          exp_rdy = 1'b0;
            logic          acc     = 1'b0;

            task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
                total++;
                if (act !== req) begin
                    bad++;
                    $display("FAIL skid=%0d %s t=%0t actual=%h required=%h", SK, name, $time, act, req);
                end
            endtask

            // Monitor: mid-cycle, compare outputs with the queue, then retire the beat the edge will consume.
            initial begin
                int n;
                forever begin
                    @(negedge clk);
                    n = sb.size();
                    exp_rdy = rst && ((SK != 0) ? (n < 2) : (n == 0 || ready));
                    chk("ready_o", DW'(bus.ready_o), DW'(exp_rdy));
                    chk("valid_o", DW'(bus.valid_o), DW'(n > 0));
                    chk("level_o", DW'(bus.level_o), DW'(n));
                    chk("data_o",  bus.data_o, (n > 0) ? sb[0] : BUB);
                    if (!rst || flush)     sb.delete();
                    else if (n > 0 && ready) void'(sb.pop_front());
                end
            end

            // Scoreboard feed: a beat offered while the stage should be ready is expected later.
            initial begin
                forever begin
                    @(negedge clk);
                    #1;
                    acc = rst && !flush && valid && exp_rdy;
                    if (acc) sb.push_back(data);
                end
            end
        end
    endgenerate

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst = 1'b0; flush = 1'b0; valid = 1'b1; ready = 1'b1; data = 16'h00A5;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        valid = 1'b0;
        repeat (2) cyc();

        for (int i = 1; i <= 16; i++) begin
            valid = 1'b1;
            data  = DW'(i);
            cyc();
        end
        valid = 1'b0;
        repeat (3) cyc();

        // skid fill: source holds each beat until the skid instance takes it
        k = 1;
        for (int c = 0; c < 20; c++) begin
            valid = 1'b1;
            data  = DW'(k);
            ready = !(c >= 5 && c < 8);
            cyc();
            if (lane[1].acc) k++;
        end
        valid = 1'b0; ready = 1'b1;
        repeat (4) cyc();

        ready = 1'b0; valid = 1'b1; data = 16'h0011;
        cyc();
        data = 16'h0022;
        cyc();
        data = 16'h0033; flush = 1'b1;
        cyc();
        flush = 1'b0; valid = 1'b0; ready = 1'b1;
        cyc();
        valid = 1'b1; data = 16'h0044;
        cyc();
        valid = 1'b0;
        repeat (3) cyc();

        for (int c = 0; c < 2000; c++) begin
            valid = ($urandom_range(3) != 0);
            ready = ($urandom_range(3) != 0);
            flush = ($urandom_range(99) < 2);
            data  = DW'($urandom);
            rst   = !(c >= 1000 && c < 1002);
            cyc();
        end

        rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b1;
        repeat (4) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
